mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 40 ++++
 rtl/mem_arbiter.sv | 85 ++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Processor/memory bus bundle for mem_arbiter: instruction port, data port, memory port, Grant.
// slave is the arbiter's view; master is the processor-plus-memory side.
interface mem_arbiter_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 InstrReq;
    logic [WORD_SIZE-1:0] InstrAddr;
    logic [WORD_SIZE-1:0] InstrRdData;
    logic                 InstrWaitreq;

    logic                 ReadData;
    logic                 WriteData;
    logic [WORD_SIZE-1:0] DataAddr;
    logic [WORD_SIZE-1:0] DataOut;
    logic [WORD_SIZE-1:0] DataIn;
    logic                 DataWaitreq;

    logic [WORD_SIZE-1:0] MemAddr;
    logic [WORD_SIZE-1:0] MemWrData;
    logic                 MemRead;
    logic                 MemWrite;
    logic [WORD_SIZE-1:0] MemRdData;
    logic                 MemWaitreq;

    logic [1:0]           Grant;

    modport slave (
        input  InstrReq, InstrAddr, ReadData, WriteData, DataAddr, DataOut,
        input  MemRdData, MemWaitreq,
        output InstrRdData, InstrWaitreq, DataIn, DataWaitreq,
        output MemAddr, MemWrData, MemRead, MemWrite, Grant
    );

    modport master (
        output InstrReq, InstrAddr, ReadData, WriteData, DataAddr, DataOut,
        output MemRdData, MemWaitreq,
        input  InstrRdData, InstrWaitreq, DataIn, DataWaitreq,
        input  MemAddr, MemWrData, MemRead, MemWrite, Grant
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data has priority, but an instruction fetch that has
// watched STARVE_LIMIT consecutive data grants wins the next arbitration.
module mem_arbiter #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           Clock,
    input logic           Reset,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StInstrBusy = 2'd1,
        StDataBusy  = 2'd2
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] starve_q;
    logic            data_req;
    logic            instr_starved;

    assign data_req      = bus.ReadData | bus.WriteData;
    assign instr_starved = bus.InstrReq && (starve_q == StarveMax);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q       <= StIdle;
            starve_q      <= '0;
            bus.Grant     <= 2'd0;
            bus.MemAddr   <= {WORD_SIZE{1'b0}};
            bus.MemWrData <= {WORD_SIZE{1'b0}};
            bus.MemRead   <= 1'b0;
            bus.MemWrite  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (data_req && !instr_starved) begin
                        state_q       <= StDataBusy;
                        bus.Grant     <= 2'd2;
                        bus.MemAddr   <= bus.DataAddr;
                        bus.MemWrData <= bus.DataOut;
                        // Read and write together resolve to a write.
                        bus.MemRead   <= bus.ReadData & ~bus.WriteData;
                        bus.MemWrite  <= bus.WriteData;
                        if (!bus.InstrReq) begin
                            starve_q <= '0;
                        end else if (starve_q != StarveMax) begin
                            starve_q <= starve_q + 1'b1;
                        end
                    end else if (bus.InstrReq) begin
                        state_q     <= StInstrBusy;
                        bus.Grant   <= 2'd1;
                        bus.MemAddr <= bus.InstrAddr;
                        bus.MemRead <= 1'b1;
                        bus.MemWrite <= 1'b0;
                        starve_q    <= '0;
                    end
                end
                StInstrBusy, StDataBusy: begin
                    // Requester dropping its request does not abort; only memory ends it.
                    if (!bus.MemWaitreq) begin
                        state_q      <= StIdle;
                        bus.Grant    <= 2'd0;
                        bus.MemRead  <= 1'b0;
                        bus.MemWrite <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    bus.Grant    <= 2'd0;
                    bus.MemRead  <= 1'b0;
                    bus.MemWrite <= 1'b0;
                end
            endcase
        end
    end

    assign bus.InstrWaitreq = bus.InstrReq & ~((state_q == StInstrBusy) & ~bus.MemWaitreq);
    assign bus.DataWaitreq  = data_req & ~((state_q == StDataBusy) & ~bus.MemWaitreq);
    assign bus.InstrRdData  = bus.MemRdData;
    assign bus.DataIn       = bus.MemRdData;
endmodule
